// File: rtl/key_move_pkg.sv
// Scan-code constants, direction indices and parser state encoding shared by
// the key movement scheduler and its testbench.
package key_move_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } parse_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } dir_hit_t;

  function automatic dir_hit_t arrow_lookup(input logic [7:0] code);
    dir_hit_t r;
    r = '{hit: 1'b1, dir: DIR_LEFT};
    case (code)
      SC_LEFT:  r.dir = DIR_LEFT;
      SC_RIGHT: r.dir = DIR_RIGHT;
      SC_UP:    r.dir = DIR_UP;
      SC_DOWN:  r.dir = DIR_DOWN;
      default:  r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic dir_hit_t wasd_lookup(input logic [7:0] code);
    dir_hit_t r;
    r = '{hit: 1'b1, dir: DIR_LEFT};
    case (code)
      SC_A:    r.dir = DIR_LEFT;
      SC_D:    r.dir = DIR_RIGHT;
      SC_W:    r.dir = DIR_UP;
      SC_S:    r.dir = DIR_DOWN;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_move_scheduler_if.sv
// Keyboard-in / movement-out bundle between the PS/2 front end, the scheduler
// and the VGA drawing logic.
interface key_move_scheduler_if #(
  parameter int POS_W = 10
);
  logic [7:0]       key_data;
  logic             key_pressed;
  logic             enable;
  logic [3:0]       held;
  logic             left;
  logic             right;
  logic             up;
  logic             down;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;

  modport master (
    output key_data, key_pressed, enable,
    input  held, left, right, up, down, pos_x, pos_y
  );

  modport slave (
    input  key_data, key_pressed, enable,
    output held, left, right, up, down, pos_x, pos_y
  );
endinterface

// File: rtl/dir_rr_arbiter.sv
// Combinational 4-way round-robin picker: first set request at or after ptr,
// wrapping, with the pointer advanced past the winner.
module dir_rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       valid,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic [1:0] ptr_next
);

  logic       found;
  logic [1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    ptr_next  = ptr;
    found     = 1'b0;
    cand      = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (valid && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        ptr_next    = cand + 2'd1;
      end
    end
  end

endmodule

// File: rtl/key_move_scheduler.sv
// Turns PS/2 scan codes into a held-direction bitmap, then grants one held
// direction per movement tick as a one-cycle pulse plus a clamped sprite move.
module key_move_scheduler
  import key_move_pkg::*;
#(
  parameter int TICK_DIV = 2500000,
  parameter int POS_W    = 10,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int STEP     = 4
) (
  input logic                 clock,
  input logic                 reset,
  key_move_scheduler_if.slave bus
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W:0]   STEP_W   = (POS_W + 1)'(STEP);
  localparam logic [POS_W:0]   X_MAX_W  = (POS_W + 1)'(X_MAX);
  localparam logic [POS_W:0]   Y_MAX_W  = (POS_W + 1)'(Y_MAX);

  parse_state_e     state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rr_q, rr_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d;
  logic [POS_W-1:0] pos_y_q, pos_y_d;

  logic             tick;
  logic [3:0]       grant;
  logic [1:0]       grant_idx;
  logic [1:0]       rr_next;
  dir_hit_t         arrow_hit;
  dir_hit_t         wasd_hit;
  logic [POS_W:0]   x_ext;
  logic [POS_W:0]   y_ext;

  // Prefix bytes only steer the state; the final code of a sequence edits held.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    arrow_hit = arrow_lookup(bus.key_data);
    wasd_hit  = wasd_lookup(bus.key_data);
    if (bus.key_pressed) begin
      case (state_q)
        PS_IDLE: begin
          if (bus.key_data == SC_EXT)      state_d = PS_EXT;
          else if (bus.key_data == SC_BRK) state_d = PS_BRK;
          else if (wasd_hit.hit)           held_d[wasd_hit.dir] = 1'b1;
        end
        PS_EXT: begin
          if (bus.key_data == SC_BRK)      state_d = PS_EXT_BRK;
          else if (bus.key_data == SC_EXT) state_d = PS_EXT;
          else begin
            if (arrow_hit.hit) held_d[arrow_hit.dir] = 1'b1;
            state_d = PS_IDLE;
          end
        end
        PS_BRK: begin
          if (wasd_hit.hit) held_d[wasd_hit.dir] = 1'b0;
          state_d = PS_IDLE;
        end
        PS_EXT_BRK: begin
          if (arrow_hit.hit) held_d[arrow_hit.dir] = 1'b0;
          state_d = PS_IDLE;
        end
        default: state_d = PS_IDLE;
      endcase
    end
  end

  always_comb begin
    tick  = bus.enable && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (bus.enable) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Arbitration sees held_q, so a same-cycle release still gets its last tick.
  dir_rr_arbiter u_arb (
    .req      (held_q),
    .ptr      (rr_q),
    .valid    (tick),
    .grant    (grant),
    .grant_idx(grant_idx),
    .ptr_next (rr_next)
  );

  always_comb begin
    rr_d    = rr_next;
    pulse_d = grant;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    x_ext   = {1'b0, pos_x_q};
    y_ext   = {1'b0, pos_y_q};
    if (|grant) begin
      case (grant_idx)
        DIR_LEFT:  pos_x_d = (x_ext < STEP_W) ? '0 : POS_W'(x_ext - STEP_W);
        DIR_RIGHT: pos_x_d = (x_ext + STEP_W > X_MAX_W) ? POS_W'(X_MAX_W)
                                                        : POS_W'(x_ext + STEP_W);
        DIR_UP:    pos_y_d = (y_ext < STEP_W) ? '0 : POS_W'(y_ext - STEP_W);
        default:   pos_y_d = (y_ext + STEP_W > Y_MAX_W) ? POS_W'(Y_MAX_W)
                                                        : POS_W'(y_ext + STEP_W);
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PS_IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      pulse_q <= '0;
      pos_x_q <= POS_W'(X_INIT);
      pos_y_q <= POS_W'(Y_INIT);
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      pulse_q <= pulse_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  assign bus.held  = held_q;
  assign bus.left  = pulse_q[0];
  assign bus.right = pulse_q[1];
  assign bus.up    = pulse_q[2];
  assign bus.down  = pulse_q[3];
  assign bus.pos_x = pos_x_q;
  assign bus.pos_y = pos_y_q;

endmodule
